product_scatter_accumulator: RTL and testbench

Receiver and accumulator for the multiplier/coordinate stage output. Each beat carries up to LANES products, each tagged with an output (row, col, k) coordinate and a per-lane valid bit. The block serializes valid lanes one per cycle into a read-modify-write accumulator SRAM addressed by {k,row,col}. On request it drains the finished partial sums through a valid/ready stream and zeroes each entry as it is read out.

---
 rtl/product_scatter_accumulator.sv | 221 ++++++++++++++++++++++
 tb/tb_product_scatter_accumulator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_scatter_accumulator.sv
// Scatter accumulator: serializes tagged product lanes into a read-modify-write sum SRAM and drains it on request.
// Optional ACC_SAT_EN: saturating accumulation with a sticky sat_flag (default build wraps, sat_flag stays 0).
module product_scatter_accumulator #(
    parameter int LANES = 4,
    parameter int DW    = 16,
    parameter int AW    = 32,
    parameter int ROW_W = 4,
    parameter int COL_W = 4,
    parameter int K_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES-1:0]           in_valid,
    input  logic [LANES*DW-1:0]        in_data,
    input  logic [LANES*ROW_W-1:0]     in_row,
    input  logic [LANES*COL_W-1:0]     in_col,
    input  logic [LANES*K_W-1:0]       in_k,
    output logic                       in_ready,
    input  logic                       drain_start,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [AW-1:0]              out_data,
    output logic [K_W+ROW_W+COL_W-1:0] out_addr,
    output logic                       drain_done,
    output logic                       sat_flag
);
    localparam int ADDR_W = K_W + ROW_W + COL_W;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN_RD, DRAIN_OUT} state_t;

    function automatic logic signed [AW:0] wide_add(input logic signed [AW-1:0] a,
                                                    input logic signed [AW-1:0] b);
        return {a[AW-1], a} + {b[AW-1], b};
    endfunction

    function automatic logic signed [AW-1:0] sat_wrap(input logic signed [AW:0] s);
        if (SAT_EN && (s[AW] != s[AW-1]))
            return s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        return s[AW-1:0];
    endfunction

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       cnt_q, cnt_d;
    logic                    drain_req_q, drain_req_d;
    logic                    drain_done_q, drain_done_d;
    logic [LANES-1:0]        pend_q, pend_d;
    logic                    sat_flag_q;

    logic [LANES*DW-1:0]     cap_data_q;
    logic [LANES*ROW_W-1:0]  cap_row_q;
    logic [LANES*COL_W-1:0]  cap_col_q;
    logic [LANES*K_W-1:0]    cap_k_q;

    logic signed [AW-1:0]    mem_q [DEPTH];

    logic                    iss_vld;
    logic [LANES-1:0]        iss_oh;
    logic [ADDR_W-1:0]       iss_addr;
    logic signed [DW-1:0]    iss_data;
    logic                    accept;

    logic                    vld_p0;
    logic [ADDR_W-1:0]       addr_p0;
    logic signed [DW-1:0]    prod_p0;
    logic signed [AW-1:0]    rd_p0;

    logic signed [AW-1:0]    prod_ext;
    logic signed [AW:0]      wide_s1;
    logic signed [AW-1:0]    sum_s1;
    logic                    ovf_s1;
    logic                    fwd;
    logic                    rd_en;
    logic [ADDR_W-1:0]       rd_addr;
    logic                    we;
    logic [ADDR_W-1:0]       wa;
    logic signed [AW-1:0]    wd;

    // Lowest-index pending lane issues each cycle.
    always_comb begin
        iss_vld  = 1'b0;
        iss_oh   = '0;
        iss_addr = '0;
        iss_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (pend_q[i] && !iss_vld) begin
                iss_vld  = 1'b1;
                iss_oh[i] = 1'b1;
                iss_addr = {cap_k_q[i*K_W +: K_W], cap_row_q[i*ROW_W +: ROW_W],
                            cap_col_q[i*COL_W +: COL_W]};
                iss_data = cap_data_q[i*DW +: DW];
            end
        end
    end

    assign in_ready = (state_q == ACCUM) && !drain_req_q && ((pend_q & ~iss_oh) == '0);
    assign accept   = in_ready && (|in_valid);
    assign pend_d   = accept ? in_valid : (pend_q & ~iss_oh);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        drain_req_d  = drain_req_q;
        drain_done_d = 1'b0;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (drain_start)
                    drain_req_d = 1'b1;
                if (drain_req_q && (pend_q == '0) && !vld_p0) begin
                    state_d = DRAIN_RD;
                    cnt_d   = '0;
                end
            end
            DRAIN_RD: state_d = DRAIN_OUT;
            DRAIN_OUT: begin
                if (out_ready) begin
                    if (cnt_q == '1) begin
                        state_d      = ACCUM;
                        cnt_d        = '0;
                        drain_req_d  = 1'b0;
                        drain_done_d = 1'b1;
                    end else begin
                        state_d = DRAIN_RD;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            drain_req_q  <= 1'b0;
            drain_done_q <= 1'b0;
            pend_q       <= '0;
            vld_p0       <= 1'b0;
            sat_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drain_req_q  <= drain_req_d;
            drain_done_q <= drain_done_d;
            pend_q       <= pend_d;
            vld_p0       <= iss_vld;
            if (vld_p0 && SAT_EN && ovf_s1)
                sat_flag_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_data_q <= in_data;
            cap_row_q  <= in_row;
            cap_col_q  <= in_col;
            cap_k_q    <= in_k;
        end
    end

    // ---- S0: read (or forward the in-flight S1 sum to the same address) ----
    assign fwd     = iss_vld && vld_p0 && (iss_addr == addr_p0);
    assign rd_en   = iss_vld || (state_q == DRAIN_RD);
    assign rd_addr = iss_vld ? iss_addr : cnt_q;

    always_ff @(posedge clk) begin
        addr_p0 <= iss_addr;
        prod_p0 <= iss_data;
        if (rd_en)
            rd_p0 <= fwd ? sum_s1 : mem_q[rd_addr];
    end

    // ---- S1: add and write back ----
    assign prod_ext = AW'(prod_p0);
    assign wide_s1  = wide_add(rd_p0, prod_ext);
    assign sum_s1   = sat_wrap(wide_s1);
    assign ovf_s1   = wide_s1[AW] ^ wide_s1[AW-1];

    // Clear, accumulate and drain-zeroing never overlap, so one write port suffices.
    always_comb begin
        we = 1'b0;
        wa = cnt_q;
        wd = '0;
        if (state_q == CLEAR) begin
            we = 1'b1;
        end else if (vld_p0) begin
            we = 1'b1;
            wa = addr_p0;
            wd = sum_s1;
        end else if ((state_q == DRAIN_OUT) && out_ready) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem_q[wa] <= wd;
    end

    assign out_valid  = (state_q == DRAIN_OUT);
    assign out_data   = out_valid ? rd_p0 : '0;
    assign out_addr   = out_valid ? cnt_q : '0;
    assign drain_done = drain_done_q;
    assign busy       = (state_q != ACCUM) || drain_req_q;
    assign sat_flag   = sat_flag_q;

endmodule

// File: tb/tb_product_scatter_accumulator.sv
// Directed bench for product_scatter_accumulator: default instance plus a small wide-product instance for overflow.
module tb_product_scatter_accumulator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [15:0] in_row, in_col;
    logic [7:0]  in_k;
    logic        in_ready, drain_start, busy, out_valid, out_ready, drain_done, sat_flag;
    logic [31:0] out_data;
    logic [9:0]  out_addr;

    product_scatter_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_row(in_row),
        .in_col(in_col), .in_k(in_k), .in_ready(in_ready), .drain_start(drain_start),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .drain_done(drain_done), .sat_flag(sat_flag)
    );

    // Wide-product instance, 8 entries
    logic [3:0]   b_in_valid;
    logic [127:0] b_in_data;
    logic [3:0]   b_in_row, b_in_col, b_in_k;
    logic         b_in_ready, b_drain_start, b_busy, b_out_valid, b_out_ready, b_drain_done, b_sat_flag;
    logic [31:0]  b_out_data;
    logic [2:0]   b_out_addr;

    product_scatter_accumulator #(.LANES(4), .DW(32), .AW(32), .ROW_W(1), .COL_W(1), .K_W(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_row(b_in_row),
        .in_col(b_in_col), .in_k(b_in_k), .in_ready(b_in_ready), .drain_start(b_drain_start),
        .busy(b_busy), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_addr(b_out_addr), .drain_done(b_drain_done), .sat_flag(b_sat_flag)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] got  [1024];
    logic [31:0] bgot [8];

    int d_hs, d_done_n, d_done_at, d_last_hs, d_order_err, d_unstable, d_rdy_seen, d_busy_lo;
    logic [31:0] d_first0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int count_nz(input int a, input int b);
        int n = 0;
        for (int i = 0; i < 1024; i++)
            if (i != a && i != b && got[i] !== 32'd0) n++;
        return n;
    endfunction

    task automatic send_a(input string tag, input logic [3:0] v, input logic [63:0] d,
                          input logic [15:0] r, input logic [15:0] c, input logic [7:0] k,
                          input bit with_drain);
        int n = 0;
        in_valid = v; in_data = d; in_row = r; in_col = c; in_k = k;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check(tag, in_ready, 1);
        drain_start = with_drain;
        step();
        in_valid = 4'b0;
        drain_start = 1'b0;
    endtask

    task automatic run_drain(input bit do_pulse, input int stall, input bit junk);
        int cyc = 0;
        int stalled = 0;
        logic [31:0] hold_d = '0;
        logic [9:0]  hold_a = '0;
        d_hs = 0; d_done_n = 0; d_done_at = -1; d_last_hs = -10; d_order_err = 0;
        d_unstable = 0; d_rdy_seen = 0; d_busy_lo = 0; d_first0 = 32'hDEADBEEF;
        for (int i = 0; i < 1024; i++) got[i] = 32'hDEADBEEF;
        if (do_pulse) begin
            drain_start = 1'b1;
            step();
            drain_start = 1'b0;
        end
        if (junk) begin
            in_valid = 4'b0001; in_data = 64'd99; in_row = '0; in_col = '0; in_k = 8'b10;
        end
        while (cyc < 4000 && !(d_done_at >= 0 && cyc > d_done_at + 3)) begin
            if (drain_done) begin
                d_done_n++;
                if (d_done_at < 0) d_done_at = cyc;
                in_valid = 4'b0;
            end
            if (d_done_n == 0 && in_ready) d_rdy_seen++;
            if (d_done_n == 0 && !busy) d_busy_lo++;
            out_ready = 1'b1;
            if (out_valid) begin
                if (d_hs == 0 && stalled < stall) begin
                    if (stalled == 0) begin
                        hold_d = out_data;
                        hold_a = out_addr;
                    end else if (out_data !== hold_d || out_addr !== hold_a) begin
                        d_unstable++;
                    end
                    stalled++;
                    out_ready = 1'b0;
                end else begin
                    if (d_hs == 0 && stall > 0 && (out_data !== hold_d || out_addr !== hold_a))
                        d_unstable++;
                    if (d_hs == 0) d_first0 = out_data;
                    if (out_addr !== d_hs[9:0]) d_order_err++;
                    got[out_addr] = out_data;
                    d_hs++;
                    d_last_hs = cyc;
                end
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int early;
        int bn;
        int bcyc;
        bit bdone;
        rst = 1'b1; in_valid = '0; in_data = '0; in_row = '0; in_col = '0; in_k = '0;
        drain_start = 1'b0; out_ready = 1'b0;
        b_in_valid = '0; b_in_data = '0; b_in_row = '0; b_in_col = '0; b_in_k = '0;
        b_drain_start = 1'b0; b_out_ready = 1'b0;
        step();
        step();

        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_drain_done", drain_done, 0);
        check("rst_sat_flag", sat_flag, 0);
        rst = 1'b0;

        // CLEAR sweeps all 1024 entries before accepting input
        n = 0; early = 0;
        in_valid = 4'b1111;
        while (!in_ready && n < 1100) begin
            if (!busy) early++;
            step();
            n++;
        end
        in_valid = 4'b0;
        check("clear_cycles", n, 1024);
        check("clear_busy_low_early", early, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_out_valid", out_valid, 0);
        check("idle_out_data", out_data, 0);
        check("idle_out_addr", out_addr, 0);
        check("idle_drain_done", drain_done, 0);

        // Single lane to {k1,row2,col3}; invalid lanes carry junk aimed at entry 0
        send_a("t1_accept", 4'b0001, {16'd77, 16'd77, 16'd77, 16'd5}, 16'h0002, 16'h0003, 8'b00_00_00_01, 0);
        run_drain(1, 0, 0);
        check("t1_entries", d_hs, 1024);
        check("t1_entry_123", got[10'h123], 32'd5);
        check("t1_others_zero", count_nz(10'h123, 10'h123), 0);
        check("t1_done_pulses", d_done_n, 1);
        check("t1_done_after_last", d_done_at, d_last_hs + 1);
        check("t1_order", d_order_err, 0);
        check("t1_busy_during", d_busy_lo, 0);
        check("t1_ready_during", d_rdy_seen, 0);
        check("t1_busy_after", busy, 0);

        // Back-to-back hits on entry 0: four beats of (1,2,3,-4) sum to 8
        for (int b = 0; b < 4; b++)
            send_a("t2_accept", 4'b1111, {16'hFFFC, 16'd3, 16'd2, 16'd1}, 16'h0, 16'h0, 8'h0, 0);
        run_drain(1, 0, 0);
        check("t2_entries", d_hs, 1024);
        check("t2_entry_0", got[0], 32'd8);
        check("t2_others_zero", count_nz(0, 0), 0);
        check("t2_done_pulses", d_done_n, 1);

        // Sparse mask 1010: only lanes 1 and 3 issue, so in_ready drops for one cycle
        send_a("t3_accept", 4'b1010, {16'hFFFF, 16'd100, 16'd7, 16'd100},
               {4'hF, 4'hF, 4'h0, 4'hF}, {4'hF, 4'hF, 4'h5, 4'hF}, {2'd3, 2'd3, 2'd0, 2'd3}, 0);
        n = 0;
        while (!in_ready && n < 10) begin
            step();
            n++;
        end
        check("t3_ready_low_cycles", n, 1);
        run_drain(1, 0, 0);
        check("t3_entry_005", got[10'h005], 32'd7);
        check("t3_entry_3ff", got[10'h3FF], 32'hFFFF_FFFF);
        check("t3_others_zero", count_nz(10'h005, 10'h3FF), 0);

        // Drain request with a full beat in the same cycle, stalled 10 cycles on entry 0
        check("t4_ready_before", in_ready, 1);
        send_a("t4_accept", 4'b1111, {16'hFFCE, 16'd30, 16'd20, 16'd10},
               {4'hF, 4'h0, 4'h0, 4'h0}, {4'hF, 4'h0, 4'h0, 4'h0}, {2'd3, 2'd0, 2'd0, 2'd0}, 1);
        run_drain(0, 10, 1);
        check("t4_first_out", d_first0, 32'd60);
        check("t4_stall_stable", d_unstable, 0);
        check("t4_no_accept", d_rdy_seen, 0);
        check("t4_entry_0", got[0], 32'd60);
        check("t4_entry_3ff", got[10'h3FF], 32'hFFFF_FFCE);
        check("t4_junk_entry", got[10'h200], 32'd0);
        check("t4_others_zero", count_nz(0, 10'h3FF), 0);
        check("t4_done_pulses", d_done_n, 1);
        check("t4_done_after_last", d_done_at, d_last_hs + 1);
        check("t4_entries", d_hs, 1024);
        check("a_sat_flag", sat_flag, 0);

        // Overflow: 0x7FFF0000 + 0x7FFF0000 on entry 0 of the wide instance
        check("b_ready", b_in_ready, 1);
        b_in_valid = 4'b0011;
        b_in_data  = {32'd0, 32'd0, 32'h7FFF_0000, 32'h7FFF_0000};
        step();
        b_in_valid = 4'b0;
        step(); step(); step();
`ifdef ACC_SAT_EN
        check("b_sat_flag", b_sat_flag, 1);
`else
        check("b_sat_flag", b_sat_flag, 0);
`endif
        for (int i = 0; i < 8; i++) bgot[i] = 32'hDEADBEEF;
        b_drain_start = 1'b1;
        step();
        b_drain_start = 1'b0;
        b_out_ready = 1'b1;
        bn = 0; bcyc = 0; bdone = 0;
        while (!bdone && bcyc < 200) begin
            if (b_out_valid) begin
                bgot[b_out_addr] = b_out_data;
                bn++;
            end
            if (b_drain_done) bdone = 1;
            step();
            bcyc++;
        end
        check("b_done", bdone, 1);
        check("b_entries", bn, 8);
`ifdef ACC_SAT_EN
        check("b_entry_0", bgot[0], 32'h7FFF_FFFF);
        check("b_sat_sticky", b_sat_flag, 1);
`else
        check("b_entry_0", bgot[0], 32'hFFFE_0000);
        check("b_sat_sticky", b_sat_flag, 0);
`endif
        n = 0;
        for (int i = 1; i < 8; i++) if (bgot[i] !== 32'd0) n++;
        check("b_others_zero", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
